// File: rtl/imm_pkg.sv
// Immediate generator shared types: format enum, opcodes, decode result.
// Imported by the decoder, the handshake interface and the pipeline top.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // imm is the 32-bit value; widening to XLEN copies bit 31,
  // which is always 0 for SHAMT, so one sign-extend serves all.
  typedef struct packed {
    logic [31:0] imm;
    imm_fmt_e    fmt;
    logic        illegal;
  } imm_res_t;

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle between the decode feeder and the immediate generator.
// master drives instructions and out_ready; slave is the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  import imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst_code;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_out;
  imm_fmt_e         imm_fmt;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid,
    output inst_code,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  imm_out,
    input  imm_fmt,
    input  illegal,
    input  out_tag
  );

  modport slave (
    input  in_valid,
    input  inst_code,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output imm_out,
    output imm_fmt,
    output illegal,
    output out_tag
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction -> imm_res_t.
// Result imm is 32 bits; the pipeline widens it to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int SHAMT_W = 5
) (
  input  logic [31:0] inst,
  output imm_res_t    res
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       sg;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign sg  = inst[31];

  always_comb begin
    res         = '0;
    res.fmt     = IMM_NONE;
    res.illegal = 1'b0;
    unique case (1'b1)
      (opc == OPC_JAL): begin
        res.fmt = IMM_J;
        res.imm = {{12{sg}}, inst[19:12], inst[20],
                   inst[30:21], 1'b0};
      end
      (opc == OPC_JALR),
      (opc == OPC_LOAD): begin
        res.fmt = IMM_I;
        res.imm = {{20{sg}}, inst[31:20]};
      end
      (opc == OPC_OPIMM): begin
        if (is_shift(f3)) begin
          res.fmt = IMM_SHAMT;
          res.imm = 32'(inst[20 +: SHAMT_W]);
        end else begin
          res.fmt = IMM_I;
          res.imm = {{20{sg}}, inst[31:20]};
        end
      end
      (opc == OPC_LUI),
      (opc == OPC_AUIPC): begin
        res.fmt = IMM_U;
        res.imm = {inst[31:12], 12'b0};
      end
      (opc == OPC_STORE): begin
        res.fmt = IMM_S;
        res.imm = {{20{sg}}, inst[31:25], inst[11:7]};
      end
      (opc == OPC_BRANCH): begin
        res.fmt = IMM_B;
        res.imm = {{19{sg}}, sg, inst[7], inst[30:25],
                   inst[11:8], 1'b0};
      end
      (opc == OPC_OP),
      (opc == OPC_SYSTEM): begin
        res.fmt = IMM_NONE;
      end
      default: begin
        res.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, output register, one-entry skid.
// in_ready is registered and high exactly while the skid slot is empty.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 8,
  parameter int SHAMT_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    imm_res_t         res;
    logic [TAG_W-1:0] tag;
  } entry_t;

  imm_res_t dec_res;
  entry_t   dec_e;
  entry_t   out_q;
  entry_t   skid_q;
  logic     out_v;
  logic     skid_v;
  logic     acc;
  logic     drain;

  imm_decode #(
    .SHAMT_W (SHAMT_W)
  ) u_dec (
    .inst (bus.inst_code),
    .res  (dec_res)
  );

  always_comb begin
    dec_e     = '0;
    dec_e.res = dec_res;
    dec_e.tag = bus.in_tag;
  end

  assign acc   = bus.in_valid & ~skid_v;
  assign drain = bus.out_ready | ~out_v;

  // Skid only fills while the output is stalled, and in_ready is
  // low whenever it is full, so a skid move never meets an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (drain) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= acc;
        if (acc) begin
          out_q <= dec_e;
        end
      end
    end else if (acc) begin
      skid_q <= dec_e;
      skid_v <= 1'b1;
    end
  end

  assign bus.in_ready  = ~skid_v;
  assign bus.out_valid = out_v;
  assign bus.imm_out   = XLEN'($signed(out_q.res.imm));
  assign bus.imm_fmt   = out_q.res.fmt;
  assign bus.illegal   = out_q.res.illegal;
  assign bus.out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances driven in lockstep,
// table vectors, handshake corner sequences and a random scoreboard run.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SHAMT_W(5)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SHAMT_W(6)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] imm;
    imm_fmt_e    fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] imm32;
    logic [63:0] imm64;
    imm_fmt_e    fmt;
    logic        ill;
  } vec_t;

  int   n_chk;
  int   n_fail;
  exp_t q32[$];
  exp_t q64[$];
  logic [7:0] tag_ctr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input imm_fmt_e f,
                              input logic il);
    exp_t e;
    e.imm = imm;
    e.fmt = f;
    e.ill = il;
    e.tag = '0;
    return e;
  endfunction

  // Reference: field values assembled with arithmetic, then signed.
  function automatic exp_t ref_model(input logic [31:0] w, input int sw);
    longint s;
    longint u;
    imm_fmt_e f;
    logic il;
    logic neg;
    u   = w;
    neg = w[31];
    s   = 0;
    il  = 1'b0;
    f   = IMM_NONE;
    case (w[6:0])
      OPC_JAL: begin
        f = IMM_J;
        s = ((u >> 21) % 1024) * 2 + ((u >> 20) % 2) * 2048
          + ((u >> 12) % 256) * 4096;
        if (neg) s = s - 64'd1048576;
      end
      OPC_JALR, OPC_LOAD: begin
        f = IMM_I;
        s = u >> 20;
        if (neg) s = s - 4096;
      end
      OPC_OPIMM: begin
        if (((u >> 12) % 8) == 1 || ((u >> 12) % 8) == 5) begin
          f = IMM_SHAMT;
          s = (u >> 20) % (64'd1 << sw);
        end else begin
          f = IMM_I;
          s = u >> 20;
          if (neg) s = s - 4096;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        f = IMM_U;
        s = (u >> 12) * 4096;
        if (neg) s = s - 64'h1_0000_0000;
      end
      OPC_STORE: begin
        f = IMM_S;
        s = (u >> 25) * 32 + ((u >> 7) % 32);
        if (neg) s = s - 4096;
      end
      OPC_BRANCH: begin
        f = IMM_B;
        s = ((u >> 8) % 16) * 2 + ((u >> 25) % 64) * 32
          + ((u >> 7) % 2) * 2048;
        if (neg) s = s - 4096;
      end
      OPC_OP, OPC_SYSTEM: f = IMM_NONE;
      default: il = 1'b1;
    endcase
    return mk(s, f, il);
  endfunction

  task automatic cmp_front(input exp_t a, input exp_t b);
    chk("imm32", 64'(bus32.imm_out), {32'b0, a.imm[31:0]});
    chk("fmt32", 64'(bus32.imm_fmt), 64'(a.fmt));
    chk("ill32", 64'(bus32.illegal), 64'(a.ill));
    chk("tag32", 64'(bus32.out_tag), 64'(a.tag));
    chk("imm64", bus64.imm_out, b.imm);
    chk("fmt64", 64'(bus64.imm_fmt), 64'(b.fmt));
    chk("tag64", 64'(bus64.out_tag), 64'(b.tag));
  endtask

  task automatic drive(input bit iv, input logic [31:0] w, input bit ordy,
                       input bit fl);
    flush           = fl;
    bus32.in_valid  = iv;
    bus32.inst_code = w;
    bus32.in_tag    = tag_ctr;
    bus32.out_ready = ordy;
    bus64.in_valid  = iv;
    bus64.inst_code = w;
    bus64.in_tag    = tag_ctr;
    bus64.out_ready = ordy;
  endtask

  // One cycle: check current outputs against the model, then drive.
  task automatic step(input bit iv, input logic [31:0] w, input bit ordy,
                      input bit fl, input exp_t e32, input exp_t e64);
    bit rdy;
    bit have;
    exp_t a;
    exp_t b;
    @(negedge clk);
    have = (q32.size() != 0);
    rdy  = (q32.size() < 2);
    chk("valid32", 64'(bus32.out_valid), 64'(have));
    chk("ready32", 64'(bus32.in_ready), 64'(rdy));
    chk("valid64", 64'(bus64.out_valid), 64'(have));
    chk("ready64", 64'(bus64.in_ready), 64'(rdy));
    if (have) cmp_front(q32[0], q64[0]);
    drive(iv, w, ordy, fl);
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if (ordy && have) begin
        a = q32.pop_front();
        b = q64.pop_front();
      end
      if (iv && rdy) begin
        e32.tag = tag_ctr;
        e64.tag = tag_ctr;
        q32.push_back(e32);
        q64.push_back(e64);
        tag_ctr++;
      end
    end
  endtask

  task automatic mstep(input bit iv, input logic [31:0] w, input bit ordy,
                       input bit fl);
    step(iv, w, ordy, fl, ref_model(w, 5), ref_model(w, 6));
  endtask

  task automatic rst_check();
    chk("rst_valid32", 64'(bus32.out_valid), 64'd0);
    chk("rst_ready32", 64'(bus32.in_ready), 64'd1);
    chk("rst_imm32", 64'(bus32.imm_out), 64'd0);
    chk("rst_fmt32", 64'(bus32.imm_fmt), 64'(IMM_NONE));
    chk("rst_ill32", 64'(bus32.illegal), 64'd0);
    chk("rst_tag32", 64'(bus32.out_tag), 64'd0);
    chk("rst_valid64", 64'(bus64.out_valid), 64'd0);
    chk("rst_imm64", bus64.imm_out, 64'd0);
  endtask

  vec_t tbl[15];
  logic [6:0] opcs[10];

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    tag_ctr = 8'h10;
    rst_n   = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    tbl[0]  = '{32'hFFF00093, 64'hFFFFFFFF, '1, IMM_I, 1'b0};
    tbl[1]  = '{32'h123450B7, 64'h12345000, 64'h12345000, IMM_U, 1'b0};
    tbl[2]  = '{32'h00002423, 64'h8, 64'h8, IMM_S, 1'b0};
    tbl[3]  = '{32'hFE000CE3, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8,
                IMM_B, 1'b0};
    tbl[4]  = '{32'hFFDFF06F, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                IMM_J, 1'b0};
    tbl[5]  = '{32'h4010D093, 64'h1, 64'h1, IMM_SHAMT, 1'b0};
    tbl[6]  = '{32'h0000007F, 64'h0, 64'h0, IMM_NONE, 1'b1};
    tbl[7]  = '{32'h800000B7, 64'h80000000, 64'hFFFFFFFF80000000,
                IMM_U, 1'b0};
    tbl[8]  = '{32'h00000033, 64'h0, 64'h0, IMM_NONE, 1'b0};
    tbl[9]  = '{32'h00000073, 64'h0, 64'h0, IMM_NONE, 1'b0};
    tbl[10] = '{32'h02111093, 64'h1, 64'h21, IMM_SHAMT, 1'b0};
    tbl[11] = '{32'h80002003, 64'hFFFFF800, 64'hFFFFFFFFFFFFF800,
                IMM_I, 1'b0};
    tbl[12] = '{32'h7FF00067, 64'h7FF, 64'h7FF, IMM_I, 1'b0};
    tbl[13] = '{32'h00017017, 64'h17000, 64'h17000, IMM_U, 1'b0};
    tbl[14] = '{32'hFFF07013, 64'hFFFFFFFF, '1, IMM_I, 1'b0};

    opcs = '{OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_LUI,
             OPC_AUIPC, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_SYSTEM};

    #12;
    rst_check();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(1'b1, tbl[i].inst, 1'b1, 1'b0,
           mk(tbl[i].imm32, tbl[i].fmt, tbl[i].ill),
           mk(tbl[i].imm64, tbl[i].fmt, tbl[i].ill));
    end
    mstep(1'b0, 32'h0, 1'b1, 1'b0);
    mstep(1'b0, 32'h0, 1'b1, 1'b0);

    // Stall: two accepted, third refused, then ordered release.
    mstep(1'b1, 32'h123450B7, 1'b0, 1'b0);
    mstep(1'b1, 32'h00002423, 1'b0, 1'b0);
    mstep(1'b1, 32'hFE000CE3, 1'b0, 1'b0);
    mstep(1'b1, 32'hFE000CE3, 1'b0, 1'b0);
    mstep(1'b1, 32'hFE000CE3, 1'b1, 1'b0);
    mstep(1'b1, 32'hFE000CE3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) mstep(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with skid full and an input offered, then with ready high.
    mstep(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    mstep(1'b1, 32'h4010D093, 1'b0, 1'b0);
    mstep(1'b1, 32'h0000007F, 1'b1, 1'b1);
    mstep(1'b1, 32'h800000B7, 1'b1, 1'b1);
    mstep(1'b0, 32'h0, 1'b1, 1'b0);
    mstep(1'b0, 32'h0, 1'b1, 1'b0);

    // Async reset while entries are held.
    mstep(1'b1, 32'h00017017, 1'b0, 1'b0);
    mstep(1'b1, 32'h7FF00067, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rst_check();
    q32.delete();
    q64.delete();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) mstep(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 500; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = opcs[$urandom_range(0, 9)];
      mstep(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 3; i++) mstep(1'b0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
